// File: rtl/load_store_unit_if.sv
// Data-memory port of the load/store unit: a req/gnt request phase followed
// by an rvalid response phase (loads and stores both get a response).
interface load_store_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    mem_req_o;
  logic                    mem_gnt_i;
  logic [DATA_WIDTH-1:0]   mem_addr_o;
  logic                    mem_we_o;
  logic [DATA_WIDTH/8-1:0] mem_be_o;
  logic [DATA_WIDTH-1:0]   mem_wdata_o;
  logic                    mem_rvalid_i;
  logic [DATA_WIDTH-1:0]   mem_rdata_i;

  modport master (
    output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding access, byte-lane formatting of stores,
// alignment and extension of loads, and a stall towards the core.
module load_store_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_req_i,
  input  logic [1:0]            data_type_i,
  input  logic                  data_we_i,
  input  logic                  data_sign_ext_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o,
  load_store_unit_if.master     mem
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [1:0] TYPE_BYTE = 2'b00;
  localparam logic [1:0] TYPE_HALF = 2'b01;
  localparam logic [1:0] TYPE_WORD = 2'b10;

  function automatic logic [3:0] fmt_be(input logic [1:0] typ, input logic [1:0] off);
    logic [3:0] be;
    case (typ)
      TYPE_BYTE: be = 4'b0001 << off;
      TYPE_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      TYPE_WORD: be = 4'b1111;
      default:   be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] fmt_wdata(input logic [1:0] typ,
                                                      input logic [DATA_WIDTH-1:0] wd);
    logic [DATA_WIDTH-1:0] res;
    case (typ)
      TYPE_BYTE: res = {4{wd[7:0]}};
      TYPE_HALF: res = {2{wd[15:0]}};
      default:   res = wd;
    endcase
    return res;
  endfunction

  // Lane select by byte offset, then mask and extend to full width.
  function automatic logic [DATA_WIDTH-1:0] extract_load(input logic [DATA_WIDTH-1:0] rd,
                                                         input logic [1:0] off,
                                                         input logic [1:0] typ,
                                                         input logic       sext);
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] res;
    shifted = rd >> {off, 3'b000};
    case (typ)
      TYPE_BYTE: res = {{(DATA_WIDTH-8){sext & shifted[7]}}, shifted[7:0]};
      TYPE_HALF: res = {{(DATA_WIDTH-16){sext & shifted[15]}}, shifted[15:0]};
      default:   res = shifted;
    endcase
    return res;
  endfunction

  logic [1:0] state_r;
  logic [1:0] type_r;
  logic [1:0] off_r;
  logic       sext_r;
  logic       err_cond_s;
  logic       idle_req_s;
  logic       accept_s;

  // Legality of the incoming access: alignment versus size, and reserved type
  always_comb begin
    err_cond_s = 1'b0;
    case (data_type_i)
      TYPE_BYTE: err_cond_s = 1'b0;
      TYPE_HALF: err_cond_s = addr_i[0];
      TYPE_WORD: err_cond_s = (addr_i[1:0] != 2'b00);
      default:   err_cond_s = 1'b1;
    endcase
  end

  // The valid_o cycle masks data_req_i so a held request is not issued twice.
  assign idle_req_s = (state_r == ST_IDLE) && data_req_i && !valid_o;
  assign accept_s   = idle_req_s && !err_cond_s;
  assign err_o      = idle_req_s && err_cond_s;
  assign busy_o     = (state_r != ST_IDLE) || accept_s;

  // Access FSM, registered memory request and registered load result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= ST_IDLE;
      type_r          <= 2'b00;
      off_r           <= 2'b00;
      sext_r          <= 1'b0;
      valid_o         <= 1'b0;
      rdata_o         <= {DATA_WIDTH{1'b0}};
      mem.mem_req_o   <= 1'b0;
      mem.mem_addr_o  <= {DATA_WIDTH{1'b0}};
      mem.mem_we_o    <= 1'b0;
      mem.mem_be_o    <= 4'b0000;
      mem.mem_wdata_o <= {DATA_WIDTH{1'b0}};
    end else begin
      valid_o <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r         <= ST_REQ;
            type_r          <= data_type_i;
            off_r           <= addr_i[1:0];
            sext_r          <= data_sign_ext_i;
            mem.mem_req_o   <= 1'b1;
            mem.mem_addr_o  <= {addr_i[DATA_WIDTH-1:2], 2'b00};
            mem.mem_we_o    <= data_we_i;
            mem.mem_be_o    <= fmt_be(data_type_i, addr_i[1:0]);
            mem.mem_wdata_o <= fmt_wdata(data_type_i, wdata_i);
          end
        end
        ST_REQ: begin
          if (mem.mem_gnt_i) begin
            state_r       <= ST_RESP;
            mem.mem_req_o <= 1'b0;
          end
        end
        ST_RESP: begin
          if (mem.mem_rvalid_i) begin
            state_r <= ST_IDLE;
            valid_o <= 1'b1;
            if (!mem.mem_we_o) begin
              rdata_o <= extract_load(mem.mem_rdata_i, off_r, type_r, sext_r);
            end
          end
        end
        default: begin
          state_r       <= ST_IDLE;
          mem.mem_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected memory
// requests and responses, a monitor pops and compares them as they appear.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        data_req_i;
  logic [1:0]  data_type_i;
  logic        data_we_i;
  logic        data_sign_ext_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  load_store_unit_if #(.DATA_WIDTH(32)) mem_bus ();

  load_store_unit #(.DATA_WIDTH(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .data_req_i      (data_req_i),
    .data_type_i     (data_type_i),
    .data_we_i       (data_we_i),
    .data_sign_ext_i (data_sign_ext_i),
    .addr_i          (addr_i),
    .wdata_i         (wdata_i),
    .busy_o          (busy_o),
    .valid_o         (valid_o),
    .rdata_o         (rdata_o),
    .err_o           (err_o),
    .mem             (mem_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_err;
    logic [31:0] rdata;
    int          cyc;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } req_t;

  resp_t       sb_q[$];
  req_t        req_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          req_count = 0;
  int          gnt_delay = 0;
  int          rvalid_delay = 0;
  logic [31:0] resp_rdata = 32'h0;
  logic        stray_rvalid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory responder: grant after gnt_delay cycles, rvalid after rvalid_delay more.
  initial begin
    int phase;
    int cnt;
    phase = 0;
    cnt = 0;
    mem_bus.mem_gnt_i    = 1'b0;
    mem_bus.mem_rvalid_i = 1'b0;
    mem_bus.mem_rdata_i  = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n !== 1'b1) begin
        phase = 0;
        cnt = 0;
        mem_bus.mem_gnt_i    = 1'b0;
        mem_bus.mem_rvalid_i = 1'b0;
      end else begin
        case (phase)
          0: begin
            mem_bus.mem_rvalid_i = stray_rvalid;
            mem_bus.mem_rdata_i  = resp_rdata;
            if (mem_bus.mem_req_o && cnt >= gnt_delay) begin
              mem_bus.mem_gnt_i = 1'b1;
              phase = 1;
              cnt = 0;
            end else begin
              mem_bus.mem_gnt_i = 1'b0;
              if (mem_bus.mem_req_o) cnt++;
            end
          end
          1: begin
            mem_bus.mem_gnt_i = 1'b0;
            if (cnt >= rvalid_delay) begin
              mem_bus.mem_rvalid_i = 1'b1;
              mem_bus.mem_rdata_i  = resp_rdata;
              phase = 2;
              cnt = 0;
            end else begin
              cnt++;
            end
          end
          default: begin
            mem_bus.mem_rvalid_i = 1'b0;
            phase = 0;
          end
        endcase
      end
    end
  end

  // Monitor: compares responses and memory requests against the queues.
  initial begin
    resp_t r;
    req_t  q;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1) begin
        if (valid_o || err_o) begin
          if (sb_q.size() == 0) begin
            check("unexpected_response", {30'd0, valid_o, err_o}, 32'd0);
          end else begin
            r = sb_q.pop_front();
            check("resp_err", {31'd0, err_o}, {31'd0, r.is_err});
            check("resp_valid", {31'd0, valid_o}, {31'd0, !r.is_err});
            check("resp_cycle", cyc, r.cyc);
            if (!r.is_err) check("rdata", rdata_o, r.rdata);
          end
        end
        if (mem_bus.mem_req_o) begin
          if (req_q.size() == 0) begin
            check("unexpected_mem_req", 32'd1, 32'd0);
          end else begin
            q = req_q[0];
            check("mem_addr", mem_bus.mem_addr_o, q.addr);
            check("mem_be", {28'd0, mem_bus.mem_be_o}, {28'd0, q.be});
            check("mem_wdata", mem_bus.mem_wdata_o, q.wdata);
            check("mem_we", {31'd0, mem_bus.mem_we_o}, {31'd0, q.we});
            if (mem_bus.mem_gnt_i) begin
              void'(req_q.pop_front());
              req_count++;
            end
          end
        end
      end
    end
  end

  task automatic do_access(input logic [1:0] typ, input logic we, input logic sext,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rsp, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                           input int gd, input int rd, input logic hold);
    req_t  q;
    resp_t r;
    bit    seen;
    seen = 1'b0;
    @(negedge clk);
    gnt_delay = gd;
    rvalid_delay = rd;
    resp_rdata = rsp;
    q.addr = addr & 32'hFFFF_FFFC;
    q.be = exp_be;
    q.wdata = exp_wdata;
    q.we = we;
    req_q.push_back(q);
    r.is_err = 1'b0;
    r.rdata = exp_rdata;
    r.cyc = cyc + 3 + gd + rd;
    sb_q.push_back(r);
    data_type_i = typ;
    data_we_i = we;
    data_sign_ext_i = sext;
    addr_i = addr;
    wdata_i = wdata;
    data_req_i = 1'b1;
    #1 check("busy_on_accept", {31'd0, busy_o}, 32'd1);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (valid_o) seen = 1'b1;
    end
    if (seen) begin
      check("busy_in_valid_cycle", {31'd0, busy_o}, 32'd0);
      if (!hold) data_req_i = 1'b0;
    end else begin
      check("valid_timeout", 32'd0, 32'd1);
      data_req_i = 1'b0;
    end
  endtask

  task automatic do_err(input logic [1:0] typ, input logic [31:0] addr);
    resp_t r;
    @(negedge clk);
    r.is_err = 1'b1;
    r.rdata = 32'h0;
    r.cyc = cyc;
    sb_q.push_back(r);
    data_type_i = typ;
    data_we_i = 1'b0;
    data_sign_ext_i = 1'b0;
    addr_i = addr;
    wdata_i = 32'h0;
    data_req_i = 1'b1;
    #1;
    check("err_busy", {31'd0, busy_o}, 32'd0);
    check("err_comb", {31'd0, err_o}, 32'd1);
    @(negedge clk);
    data_req_i = 1'b0;
    #1;
    check("err_no_mem_req", {31'd0, mem_bus.mem_req_o}, 32'd0);
    check("err_stays_idle", {31'd0, busy_o}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"}, {31'd0, mem_bus.mem_req_o}, 32'd0);
    check({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
    check({tag, "_rdata"}, rdata_o, 32'd0);
    check({tag, "_be"}, {28'd0, mem_bus.mem_be_o}, 32'd0);
    check({tag, "_addr"}, mem_bus.mem_addr_o, 32'd0);
    check({tag, "_wdata"}, mem_bus.mem_wdata_o, 32'd0);
    check({tag, "_we"}, {31'd0, mem_bus.mem_we_o}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    check({tag, "_err"}, {31'd0, err_o}, 32'd0);
  endtask

  initial begin
    int   base;
    req_t q;
    rst_n = 1'b0;
    data_req_i = 1'b0;
    data_type_i = 2'b00;
    data_we_i = 1'b0;
    data_sign_ext_i = 1'b0;
    addr_i = 32'h0;
    wdata_i = 32'h0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Word load, minimum latency
    do_access(2'b10, 1'b0, 1'b0, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF,
              4'b1111, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0);
    // Byte load from lane 3, signed then unsigned
    do_access(2'b00, 1'b0, 1'b1, 32'h0000_1003, 32'h0, 32'h8012_3456,
              4'b1000, 32'h0, 32'hFFFF_FF80, 0, 0, 1'b0);
    do_access(2'b00, 1'b0, 1'b0, 32'h0000_1003, 32'h0, 32'h8012_3456,
              4'b1000, 32'h0, 32'h0000_0080, 0, 0, 1'b0);
    // Half store, upper lanes, grant stalled three cycles; rdata_o keeps last load
    do_access(2'b01, 1'b1, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 32'h1111_1111,
              4'b1100, 32'hABCD_ABCD, 32'h0000_0080, 3, 0, 1'b0);
    // Illegal accesses
    do_err(2'b10, 32'h0000_1001);
    do_err(2'b11, 32'h0000_1000);
    do_err(2'b01, 32'h0000_1003);

    // Back-to-back with data_req_i held through the valid cycle
    base = req_count;
    do_access(2'b01, 1'b0, 1'b1, 32'h0000_3002, 32'h0, 32'h8001_7FFF,
              4'b1100, 32'h0, 32'hFFFF_8001, 0, 0, 1'b1);
    do_access(2'b00, 1'b1, 1'b0, 32'h0000_3001, 32'h1234_5678, 32'h0,
              4'b0010, 32'h7878_7878, 32'hFFFF_8001, 0, 2, 1'b0);
    check("b2b_request_count", req_count - base, 32'd2);

    // Reset while waiting for the response
    @(negedge clk);
    gnt_delay = 0;
    rvalid_delay = 6;
    resp_rdata = 32'h5555_5555;
    q.addr = 32'h0000_5000;
    q.be = 4'b1111;
    q.wdata = 32'h0;
    q.we = 1'b0;
    req_q.push_back(q);
    data_type_i = 2'b10;
    data_we_i = 1'b0;
    addr_i = 32'h0000_5000;
    wdata_i = 32'h0;
    data_req_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 check("busy_in_resp", {31'd0, busy_o}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    data_req_i = 1'b0;
    #1 check_all_zero("midreset");
    req_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stray_rvalid = 1'b1;
    @(negedge clk);
    stray_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("post_reset_valid", {31'd0, valid_o}, 32'd0);
    check("post_reset_rdata", rdata_o, 32'd0);
    check("post_reset_busy", {31'd0, busy_o}, 32'd0);

    // Normal access after reset
    do_access(2'b10, 1'b0, 1'b0, 32'h0000_4004, 32'h0, 32'hCAFE_F00D,
              4'b1111, 32'h0, 32'hCAFE_F00D, 0, 0, 1'b0);

    repeat (3) @(negedge clk);
    check("responses_drained", sb_q.size(), 32'd0);
    check("requests_drained", req_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the core's execute stage and the data-memory port. It accepts one access per instruction from the decoder/controller (request, type, direction, sign-extension) with the ALU-computed address and the rs2 store data. It runs a req/gnt/rvalid handshake with data memory, generates byte enables and lane-replicated write data, and aligns and extends load data. It stalls the core until the access completes.

## Interface
- DATA_WIDTH, 32, data and address width; only 32 is supported.
- clk  in  1  core clock.
- rst_n  in  1  reset; asynchronous, active-low.
- data_req_i  in  1  access requested by the current instruction; held high while busy_o=1.
- data_type_i  in  2  00 byte, 01 halfword, 10 word, 11 invalid.
- data_we_i  in  1  1 store, 0 load.
- data_sign_ext_i  in  1  load result is sign-extended (1) or zero-extended (0).
- addr_i  in  32  byte address from the ALU.
- wdata_i  in  32  store data (rs2); low byte/half is used for narrow stores.
- busy_o  out  1  stall request to the controller.
- valid_o  out  1  one-cycle pulse: access complete, rdata_o valid for loads.
- rdata_o  out  32  aligned, extended load result.
- err_o  out  1  one-cycle misaligned/invalid-type indication; no memory access is made.
- mem_req_o  out  1  memory request.
- mem_gnt_i  in  1  memory grant.
- mem_addr_o  out  32  word-aligned address: addr[31:2], 00.
- mem_we_o  out  1  memory write enable.
- mem_be_o  out  4  byte enables.
- mem_wdata_o  out  32  write data.
- mem_rvalid_i  in  1  response valid (for both loads and stores).
- mem_rdata_i  in  32  read data.

## Operation
- FSM states:
  - IDLE: no access in flight.
  - REQ: mem_req_o=1, waiting for grant.
  - RESP: waiting for mem_rvalid_i.
- Accept condition: IDLE and data_req_i and !valid_o and !err_cond.
  - err_cond: type 11; halfword with addr[0]=1; word with addr[1:0]≠00.
- On accept: register the address, type, we, sign_ext, and the formatted wdata/be. Go to REQ.
- REQ: on mem_gnt_i, go to RESP. mem_req_o and all mem_* outputs stay stable until grant.
- RESP: on mem_rvalid_i, go to IDLE, set valid_o=1 next cycle, and (load only) register rdata_o.
- Byte enables:
  - Byte: 0001 shifted left by addr[1:0].
  - Half: 0011 if addr[1]=0, else 1100.
  - Word: 1111.
- Write data: byte replicated ×4; half replicated ×2; word unchanged.
- Load extraction: mem_rdata_i shifted right by 8×addr[1:0], masked to 8/16/32 bits, then sign- or zero-extended to 32 bits.
- Stores leave rdata_o unchanged.
- Misaligned or invalid access in IDLE:
  - err_o=1 combinationally in that cycle.
  - busy_o=0 and valid_o=0.
  - No state change and no mem_req_o.
- busy_o = (state≠IDLE) or (IDLE and data_req_i and !valid_o and !err_cond).
  - In the valid_o cycle, busy_o=0. The controller advances and data_req_i is ignored that cycle, which prevents a double issue.
- Only one access is outstanding; there is no pipelining of requests.

## Timing
- Reset values: state IDLE; all outputs 0 (mem_req_o, valid_o, rdata_o, mem_be_o, mem_addr_o, mem_wdata_o, mem_we_o, busy_o, err_o).
- Reset asserted mid-access: return to IDLE immediately. mem_req_o drops asynchronously. A pending response is dropped and valid_o is not asserted.
- Minimum latency, with grant in the first REQ cycle and rvalid in the cycle after grant:
  - Cycle 0: accept.
  - Cycle 1: REQ.
  - Cycle 2: RESP with rvalid.
  - Cycle 3: valid_o.
  - busy_o is high in cycles 0–2.
- Each gnt stall or rvalid stall adds one cycle per stalled cycle.
- mem_rvalid_i outside RESP is ignored. mem_gnt_i outside REQ is ignored.
- mem_* outputs are registered: no combinational path from data_req_i or addr_i to mem_*.

## Test plan
- Word load, addr 0x1000, gnt immediate, rvalid next cycle, rdata 0xDEADBEEF -> mem_addr_o 0x1000, be 1111, valid_o in cycle 3, rdata_o 0xDEADBEEF.
- Byte load signed, addr 0x1003, rdata 0x80123456 -> be 1000, rdata_o 0xFFFFFF80. Same access unsigned -> 0x00000080.
- Half store, addr 0x2002, wdata 0x0000ABCD, gnt delayed 3 cycles -> mem_req_o held with be 1100, wdata 0xABCDABCD, mem_we_o=1. valid_o after rvalid; rdata_o unchanged.
- Misaligned word load, addr 0x1001 -> err_o=1 same cycle, busy_o=0, mem_req_o never asserted. Type 11 gives the same response.
- Back-to-back: data_req_i held high through the valid_o cycle, then a second access -> exactly two memory requests. The second is accepted only after the valid_o cycle.
- rst_n pulled low while in RESP, then rvalid arrives -> outputs all 0, no valid_o pulse. The next access after reset completes normally.
